mem_arbiter: RTL

Two-requester arbiter and sequencer for the SOC's single-port synchronous word memory. It sits between the memory and its requesters:

- Port 0 is the processor fetch/load/store path.
- Port 1 is a second master, such as a UART program loader or DMA.

It serializes their transactions, drives the memory's read strobe and write mask, waits out the memory's read latency, and returns registered read data with a one-cycle acknowledge. Arbitration is round-robin, so neither requester starves.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port synchronous
// word memory. Serializes port 0 / port 1 transactions, drives the read strobe
// and write mask, waits out the read latency and returns registered read data
// with a one-cycle acknowledge.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wmask,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wmask,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rstrb,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    // Wait counter is preloaded with MEM_LAT-1 so that WAIT lasts MEM_LAT cycles.
    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_t      state;
    state_t      state_next;
    logic        we_q;
    logic [3:0]  mask_q;
    logic [1:0]  cnt;
    logic        grant_valid;
    logic        grant_port;

    // Round-robin choice: a lone request wins, a tie goes to the port that did not own last.
    always_comb begin
        grant_valid = m0_req | m1_req;
        grant_port  = m1_req;
        if (m0_req && m1_req) begin
            grant_port = ~owner;
        end
    end

    // Next-state and memory/acknowledge outputs, all decoded from the current state.
    always_comb begin
        state_next = state;
        mem_rstrb  = 1'b0;
        mem_wmask  = 4'b0000;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    mem_wmask  = mask_q;
                    state_next = DONE;
                end else begin
                    mem_rstrb  = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                m0_ack     = ~owner;
                m1_ack     = owner;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Transaction latch, latency counter and per-port read data capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner     <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            mask_q    <= 4'b0000;
            cnt       <= 2'd0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                owner     <= grant_port;
                mem_addr  <= grant_port ? m1_addr  : m0_addr;
                mem_wdata <= grant_port ? m1_wdata : m0_wdata;
                we_q      <= grant_port ? m1_we    : m0_we;
                mask_q    <= grant_port ? m1_wmask : m0_wmask;
            end
            if (state == ACCESS) begin
                cnt <= CNT_INIT;
            end
            if (state == WAIT) begin
                if (cnt == 2'd0) begin
                    if (owner) begin
                        m1_rdata <= mem_rdata;
                    end else begin
                        m0_rdata <= mem_rdata;
                    end
                end else begin
                    cnt <= cnt - 2'd1;
                end
            end
        end
    end

endmodule
